// File: rtl/darkdbgtx.sv
// Debug-bus serializer: snapshots the four DEBUG words on TRIG and sends an
// 18-byte framed, XOR-checksummed stream on a UART 8N1 line.
`timescale 1ns/1ps
module darkdbgtx #(
    parameter int BAUD_DIV = 868
) (
    input  logic             XCLK,
    input  logic             XRES,
    input  logic [3:0][31:0] DEBUG,
    input  logic             TRIG,
    output logic             BUSY,
    output logic             DONE,
    output logic             TXD
);
    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_SEND    = 1'b1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [7:0]  SYNC      = 8'hA5;

    logic [0:0]   state;
    logic [127:0] snap;
    logic [15:0]  baud_cnt;
    logic [3:0]   bit_cnt;
    logic [4:0]   byte_cnt;
    logic [7:0]   csum;
    logic [7:0]   shift;
    logic         txd_q;
    logic         done_q;
    logic [7:0]   data_byte;
    logic [7:0]   next_byte;

    // Byte n+1 of the frame is snapshot byte n; DEBUG[0] LSB sits at snap[7:0].
    assign data_byte = snap[{byte_cnt[3:0], 3'b000} +: 8];
    assign next_byte = (byte_cnt == 5'd16) ? csum : data_byte;

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state    <= S_IDLE;
            snap     <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            shift    <= '0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (TRIG) begin
                        snap     <= DEBUG;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        shift    <= SYNC;
                        txd_q    <= 1'b0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (byte_cnt == 5'd17) begin
                                byte_cnt <= '0;
                                txd_q    <= 1'b1;
                                done_q   <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                // Load the next byte and start its start bit.
                                byte_cnt <= byte_cnt + 5'd1;
                                shift    <= next_byte;
                                txd_q    <= 1'b0;
                                if (byte_cnt != 5'd16)
                                    csum <= csum ^ next_byte;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                txd_q <= 1'b1;
                            end else begin
                                txd_q <= shift[0];
                                shift <= {1'b0, shift[7:1]};
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY = state[0];
    assign DONE = done_q;
    assign TXD  = txd_q;
endmodule

// File: tb/tb_darkdbgtx.sv
// Bench for darkdbgtx: frame model feeds an expected-byte queue; a UART
// monitor decodes TXD mid-bit and checks bytes against that queue.
`timescale 1ns/1ps
module tb_darkdbgtx;
    localparam int B     = 4;
    localparam int FRAME = 180 * B;

    logic             XCLK = 1'b0;
    logic             XRES = 1'b0;
    logic             TRIG = 1'b0;
    logic [3:0][31:0] DEBUG = '0;
    logic             BUSY, DONE, TXD;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    darkdbgtx #(.BAUD_DIV(B)) dut (
        .XCLK(XCLK), .XRES(XRES), .DEBUG(DEBUG), .TRIG(TRIG),
        .BUSY(BUSY), .DONE(DONE), .TXD(TXD)
    );

    always #5 XCLK = ~XCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Reference frame: sync, each word LSB first in word order, XOR of data.
    task automatic push_frame(input logic [3:0][31:0] w);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) begin
                b = 8'((w[j] >> (8 * k)) & 32'hFF);
                x = x ^ b;
                exp_q.push_back(b);
            end
        exp_q.push_back(x);
    endtask

    function automatic logic [3:0][31:0] rnd_words();
        logic [3:0][31:0] r;
        for (int j = 0; j < 4; j++) r[j] = $urandom;
        return r;
    endfunction

    // UART monitor: samples each bit B/2-1 negedges after the 0.5-cycle detect point.
    int         mt;
    bit         mact = 1'b0;
    logic [7:0] mbyte;
    always @(negedge XCLK) begin
        if (!XRES) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (TXD === 1'b0) begin
                mact = 1'b1;
                mt = 0;
            end
        end else begin
            mt++;
            if (mt % B == B / 2 - 1) begin : sample
                int b;
                b = mt / B;
                if (b == 0) chk("start_bit", 32'(TXD), 32'd0);
                else if (b <= 8) mbyte[b-1] = TXD;
                else begin
                    chk("stop_bit", 32'(TXD), 32'd1);
                    mact = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got %0h, want none", mbyte);
                    end else begin
                        chk("byte", 32'(mbyte), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge XCLK);
        #1;
    endtask

    task automatic start_frame(input logic [3:0][31:0] w, input bit hold);
        DEBUG = w;
        TRIG  = 1'b1;
        push_frame(w);
        cyc();
        if (!hold) TRIG = 1'b0;
        chk("busy_rise", 32'(BUSY), 32'd1);
        chk("start_txd", 32'(TXD), 32'd0);
    endtask

    task automatic finish_frame(input int poke_at, input bit scramble, input logic [3:0][31:0] scr);
        int cnt;
        int early;
        cnt = 1;
        early = 0;
        while (BUSY === 1'b1 && cnt <= FRAME + 5) begin
            if (scramble && cnt == 10) DEBUG = scr;
            if (cnt == poke_at) TRIG = 1'b1;
            if (cnt == poke_at + 1) TRIG = 1'b0;
            cyc();
            if (DONE === 1'b1 && BUSY === 1'b1) early++;
            if (BUSY === 1'b1) cnt++;
        end
        chk("busy_cycles", 32'(cnt), 32'(FRAME));
        chk("done_pulse", 32'(DONE), 32'd1);
        chk("idle_txd", 32'(TXD), 32'd1);
        chk("done_early", 32'(early), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic gap();
        cyc();
        chk("done_low", 32'(DONE), 32'd0);
        chk("gap_busy", 32'(BUSY), 32'd0);
        chk("gap_txd", 32'(TXD), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][31:0] w;
        int dn;
        repeat (3) @(posedge XCLK);
        #1;
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_txd", 32'(TXD), 32'd1);
        XRES = 1'b1;
        gap();

        // Basic frame: A5 78 56 34 12, twelve 00, checksum 08
        start_frame({32'h0, 32'h0, 32'h0, 32'h12345678}, 1'b0);
        finish_frame(-1, 1'b0, '0);
        gap();

        // Snapshot isolation: DEBUG overwritten 10 cycles in
        start_frame({32'hDEADBEEF, 32'h0, 32'h0, 32'hCAFEF00D}, 1'b0);
        finish_frame(-1, 1'b1, '1);
        gap();

        // All ones: checksum 00
        start_frame('1, 1'b0);
        finish_frame(-1, 1'b0, '0);
        gap();

        // Trigger pulse at cycle 100 is ignored
        start_frame(rnd_words(), 1'b0);
        finish_frame(100, 1'b0, '0);
        gap();

        // Held trigger: next frame starts one cycle after DONE
        start_frame(rnd_words(), 1'b1);
        finish_frame(-1, 1'b0, '0);
        w = rnd_words();
        DEBUG = w;
        push_frame(w);
        cyc();
        TRIG = 1'b0;
        chk("retrigger_busy", 32'(BUSY), 32'd1);
        chk("retrigger_txd", 32'(TXD), 32'd0);
        chk("retrigger_done", 32'(DONE), 32'd0);
        finish_frame(-1, 1'b0, '0);
        gap();

        // Reset mid-frame at cycle 300
        start_frame(rnd_words(), 1'b0);
        repeat (299) cyc();
        #2;
        XRES = 1'b0;
        #1;
        chk("async_txd", 32'(TXD), 32'd1);
        chk("async_busy", 32'(BUSY), 32'd0);
        chk("async_done", 32'(DONE), 32'd0);
        dn = 0;
        repeat (10) begin
            cyc();
            if (DONE === 1'b1) dn++;
        end
        chk("reset_no_done", 32'(dn), 32'd0);
        XRES = 1'b1;
        exp_q.delete();
        gap();
        start_frame(rnd_words(), 1'b0);
        finish_frame(-1, 1'b0, '0);
        gap();

        // Random frames with random DEBUG churn during transmission
        for (int i = 0; i < 4; i++) begin
            start_frame(rnd_words(), 1'b0);
            finish_frame(-1, 1'b1, rnd_words());
            gap();
        end

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
